// File: rtl/imem_boot_ctrl_if.sv
// ============================================================================
// Module : imem_boot_ctrl_if
// Brief  : Host-side and instruction-memory-side signal bundle for imem_boot_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RUN_W  = 16
);
  // Host control
  logic              load_req;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W-1:0] load_len;
  logic              run_req;
  logic [RUN_W-1:0]  run_cycles;
  logic              halt_req;
  logic [DATA_W-1:0] exp_sum;

  // Host word stream
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  // CPU / instruction-memory side and status
  logic              cpu_en;
  logic              w_enable;
  logic [ADDR_W-1:0] w_adrs;
  logic [DATA_W-1:0] w_instruction;
  logic [1:0]        state;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  modport master (
    output load_req, load_base, load_len, run_req, run_cycles, halt_req, exp_sum,
    output s_valid, s_data,
    input  s_ready,
    input  cpu_en, w_enable, w_adrs, w_instruction, state, done, error, checksum
  );

  modport slave (
    input  load_req, load_base, load_len, run_req, run_cycles, halt_req, exp_sum,
    input  s_valid, s_data,
    output s_ready,
    output cpu_en, w_enable, w_adrs, w_instruction, state, done, error, checksum
  );
endinterface

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// ============================================================================
// Module : imem_boot_ctrl
// Brief  : Streams host words into instruction memory, then enables the CPU for
//          a bounded/unbounded run. Optional checksum gate: IMEM_BOOT_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_boot_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RUN_W  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  imem_boot_ctrl_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_LOAD = 2'b01;
  localparam logic [1:0] c_RUN  = 2'b10;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_w_adrs;
  logic [DATA_W-1:0] r_w_instr;
  logic [RUN_W-1:0]  r_limit;
  logic [RUN_W-1:0]  r_cyc;
  logic              r_w_en;
  logic              r_done;
  logic              r_error;

  logic              w_idle;
  logic              w_load;
  logic              w_run;
  logic              w_s_ready;
  logic              w_hs;
  logic              w_load_last;
  logic              w_load_empty;
  logic              w_run_last;
  logic              w_req_busy;
  logic              w_sum_ok;
  logic [ADDR_W-1:0] w_count_nxt;
  logic [RUN_W-1:0]  w_cyc_nxt;

  assign w_idle = (r_state == c_IDLE);
  assign w_load = (r_state == c_LOAD);
  assign w_run  = (r_state == c_RUN);

  // Ready only while words remain; this also keeps a zero-length load write-free.
  assign w_s_ready    = w_load && (r_count != r_len);
  assign w_hs         = w_s_ready && bus.s_valid;
  assign w_count_nxt  = r_count + ADDR_W'(1);
  assign w_load_last  = (w_count_nxt == r_len);
  assign w_load_empty = (r_count == r_len);

  assign w_cyc_nxt  = r_cyc + RUN_W'(1);
  assign w_run_last = (r_limit != '0) && (w_cyc_nxt == r_limit);

  assign w_req_busy = bus.load_req || bus.run_req;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_checksum <= '0;
    end else if (w_idle && bus.load_req) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + bus.s_data;
    end
  end

  assign w_sum_ok     = (r_checksum == bus.exp_sum);
  assign bus.checksum = r_checksum;
`else
  assign w_sum_ok     = 1'b1;
  assign bus.checksum = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_w_adrs  <= '0;
      r_w_instr <= '0;
      r_limit   <= '0;
      r_cyc     <= '0;
      r_w_en    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        c_IDLE: begin
          // Load has priority; a coincident run request is dropped.
          if (bus.load_req) begin
            r_state <= c_LOAD;
            r_base  <= bus.load_base;
            r_len   <= bus.load_len;
            r_count <= '0;
            r_error <= 1'b0;
          end else if (bus.run_req) begin
            if (w_sum_ok) begin
              r_state <= c_RUN;
              r_limit <= bus.run_cycles;
              r_cyc   <= '0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end

        c_LOAD: begin
          if (w_req_busy) begin
            r_error <= 1'b1;
          end
          // A handshake in the halt cycle still lands in memory.
          if (w_hs) begin
            r_w_en    <= 1'b1;
            r_w_adrs  <= r_base + r_count;
            r_w_instr <= bus.s_data;
            r_count   <= w_count_nxt;
          end
          if (bus.halt_req) begin
            r_state <= c_IDLE;
          end else if (w_load_empty || (w_hs && w_load_last)) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
          end
        end

        c_RUN: begin
          if (w_req_busy) begin
            r_error <= 1'b1;
          end
          r_cyc <= w_cyc_nxt;
          if (bus.halt_req) begin
            r_state <= c_IDLE;
          end else if (w_run_last) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready       = w_s_ready;
  assign bus.cpu_en        = w_run;
  assign bus.w_enable      = r_w_en;
  assign bus.w_adrs        = r_w_adrs;
  assign bus.w_instruction = r_w_instr;
  assign bus.state         = r_state;
  assign bus.done          = r_done;
  assign bus.error         = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
// ============================================================================
// Module : tb_imem_boot_ctrl
// Brief  : Randomized self-checking bench for imem_boot_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  imem_boot_ctrl_if #(.ADDR_W(11), .DATA_W(32), .RUN_W(16)) bus ();

  imem_boot_ctrl #(.ADDR_W(11), .DATA_W(32), .RUN_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, written only here
  logic [10:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          mon_done = 0;
  int          done_cyc = -1;
  int          mon_cpu = 0;
  int          cpu_start = -1;
  logic        prev_cpu = 1'b0;

  always @(negedge clk) begin
    if (bus.w_enable === 1'b1) begin
      obs_addr.push_back(bus.w_adrs);
      obs_data.push_back(bus.w_instruction);
      obs_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      mon_done++;
      done_cyc = cyc;
    end
    if (bus.cpu_en === 1'b1) begin
      if (!prev_cpu) cpu_start = cyc;
      mon_cpu++;
    end
    prev_cpu = (bus.cpu_en === 1'b1);
  end

  // Driver-side state
  int          hs_cyc[$];
  logic [31:0] words[$];
  logic        first_ready;
  logic [1:0]  first_state;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load and stream words[] with optional valid gaps (mode 1 alternate, 2 random).
  // halt_at >= 0 raises halt_req together with a forced-valid word of that index.
  task automatic do_load(input logic [10:0] base, input logic [10:0] len, input int mode,
                         input int halt_at, input bit with_run);
    int i;
    int guard;
    bit hs;
    bit halting;
    hs_cyc.delete();
    bus.load_req   = 1'b1;
    bus.load_base  = base;
    bus.load_len   = len;
    bus.run_req    = with_run;
    bus.run_cycles = 16'd5;
    tick();
    bus.load_req  = 1'b0;
    bus.run_req   = 1'b0;
    bus.load_base = 11'($urandom);
    bus.load_len  = 11'($urandom);
    @(negedge clk);
    first_ready = bus.s_ready;
    first_state = bus.state;
    @(posedge clk);
    #1;
    i = 0;
    guard = 0;
    while (i < int'(len) && guard < 4000) begin
      halting = (i == halt_at);
      if (!halting && ((mode == 1 && (guard % 2) == 1) ||
                       (mode == 2 && $urandom_range(0, 99) < 35))) begin
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = words[i];
      end
      bus.halt_req = halting;
      @(negedge clk);
      hs = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
      if (hs) hs_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      bus.halt_req = 1'b0;
      if (hs) i++;
      guard++;
      if (halting) break;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.state, bus.s_ready, bus.cpu_en, bus.w_enable, bus.w_adrs, bus.w_instruction,
         bus.done, bus.error, bus.checksum} !== '0) begin
      $display("FAIL reset_outputs: state=%b s_ready=%b cpu_en=%b w_enable=%b w_adrs=%h w_instr=%h done=%b error=%b checksum=%h, required all 0",
               bus.state, bus.s_ready, bus.cpu_en, bus.w_enable, bus.w_adrs, bus.w_instruction,
               bus.done, bus.error, bus.checksum);
      bad++;
    end
    resetn = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.state !== 2'b00 || bus.cpu_en !== 1'b0) begin
      $display("FAIL reset_idle: state=%b cpu_en=%b, required 00/0", bus.state, bus.cpu_en);
      bad++;
    end
  endtask

  task automatic test_loads();
    logic [10:0] base;
    logic [10:0] len;
    int mode;
    int w0;
    int d0;
    int n;
    int ea;
    for (int t = 0; t < 6; t++) begin
      words.delete();
      if (t == 0) begin
        base = 11'h001; len = 11'd3; mode = 0;
        words.push_back(32'hE0000007);
        words.push_back(32'hC6000003);
        words.push_back(32'h12345678);
      end else if (t == 1) begin
        base = 11'h7FE; len = 11'd3; mode = 1;
        for (int k = 0; k < 3; k++) words.push_back($urandom);
      end else begin
        base = 11'($urandom); len = 11'($urandom_range(1, 10)); mode = 2;
        for (int k = 0; k < int'(len); k++) words.push_back($urandom);
      end
      w0 = obs_addr.size();
      d0 = mon_done;
      do_load(base, len, mode, -1, 1'b0);

      total++;
      if (first_ready !== 1'b1 || first_state !== 2'b01) begin
        $display("FAIL load_start[%0d]: s_ready=%b state=%b, required 1/01", t, first_ready, first_state);
        bad++;
      end
      n = obs_addr.size() - w0;
      total++;
      if (n != int'(len) || hs_cyc.size() != int'(len)) begin
        $display("FAIL load_count[%0d]: writes=%0d handshakes=%0d, required %0d", t, n, hs_cyc.size(), len);
        bad++;
      end
      if (n > hs_cyc.size()) n = hs_cyc.size();
      for (int k = 0; k < n; k++) begin
        ea = (int'(base) + k) % 2048;
        total++;
        if (obs_addr[w0+k] !== 11'(ea) || obs_data[w0+k] !== words[k] || obs_cyc[w0+k] != hs_cyc[k] + 1) begin
          $display("FAIL load_write[%0d.%0d]: adrs=%h data=%h cyc=%0d, required adrs=%h data=%h cyc=%0d",
                   t, k, obs_addr[w0+k], obs_data[w0+k], obs_cyc[w0+k], 11'(ea), words[k], hs_cyc[k] + 1);
          bad++;
        end
      end
      total++;
      if (mon_done - d0 != 1 || (hs_cyc.size() > 0 && done_cyc != hs_cyc[hs_cyc.size()-1] + 1)) begin
        $display("FAIL load_done[%0d]: pulses=%0d at cyc=%0d, required 1 pulse one cycle after last handshake",
                 t, mon_done - d0, done_cyc);
        bad++;
      end
      total++;
      if (bus.state !== 2'b00 || bus.s_ready !== 1'b0 || bus.cpu_en !== 1'b0 || bus.error !== 1'b0) begin
        $display("FAIL load_end[%0d]: state=%b s_ready=%b cpu_en=%b error=%b, required 00/0/0/0",
                 t, bus.state, bus.s_ready, bus.cpu_en, bus.error);
        bad++;
      end
    end
  endtask

  task automatic test_bounded_run();
    logic [15:0] lim;
    int c0;
    int d0;
    int req;
    for (int t = 0; t < 4; t++) begin
      lim = (t == 0) ? 16'd10 : (t == 1) ? 16'd1 : (t == 2) ? 16'd2 : 16'($urandom_range(3, 60));
      c0 = mon_cpu;
      d0 = mon_done;
      bus.run_req    = 1'b1;
      bus.run_cycles = lim;
      req = cyc;
      tick();
      bus.run_req    = 1'b0;
      bus.run_cycles = 16'($urandom);
      repeat (int'(lim) + 4) tick();
      total++;
      if (mon_cpu - c0 != int'(lim) || cpu_start != req + 1) begin
        $display("FAIL run_cycles[%0d]: cpu_en cycles=%0d start=%0d, required %0d starting at %0d",
                 t, mon_cpu - c0, cpu_start, lim, req + 1);
        bad++;
      end
      total++;
      if (mon_done - d0 != 1 || done_cyc != req + 1 + int'(lim) || bus.state !== 2'b00) begin
        $display("FAIL run_done[%0d]: pulses=%0d at cyc=%0d state=%b, required 1 at %0d and 00",
                 t, mon_done - d0, done_cyc, bus.state, req + 1 + int'(lim));
        bad++;
      end
    end
  endtask

  task automatic test_unbounded_halt();
    int c0;
    int d0;
    // halt in IDLE does nothing
    d0 = mon_done;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tick();
    total++;
    if (bus.state !== 2'b00 || bus.error !== 1'b0 || mon_done != d0) begin
      $display("FAIL idle_halt: state=%b error=%b done_pulses=%0d, required 00/0/0", bus.state, bus.error, mon_done - d0);
      bad++;
    end

    // unlimited run, halt in the 25th enabled cycle
    c0 = mon_cpu;
    d0 = mon_done;
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd0;
    tick();
    bus.run_req = 1'b0;
    repeat (24) tick();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cpu_en !== 1'b0 || bus.state !== 2'b00) begin
      $display("FAIL halt_drop: cpu_en=%b state=%b, required 0/00", bus.cpu_en, bus.state);
      bad++;
    end
    @(posedge clk);
    #1;
    repeat (2) tick();
    total++;
    if (mon_cpu - c0 != 25 || mon_done != d0 || bus.error !== 1'b0) begin
      $display("FAIL halt_run: cpu_en cycles=%0d done_pulses=%0d error=%b, required 25/0/0",
               mon_cpu - c0, mon_done - d0, bus.error);
      bad++;
    end

    // halt coincides with the final limited cycle
    c0 = mon_cpu;
    d0 = mon_done;
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd8;
    tick();
    bus.run_req = 1'b0;
    repeat (7) tick();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    repeat (3) tick();
    total++;
    if (mon_cpu - c0 != 8 || mon_done != d0 || bus.state !== 2'b00) begin
      $display("FAIL halt_vs_limit: cpu_en cycles=%0d done_pulses=%0d state=%b, required 8/0/00",
               mon_cpu - c0, mon_done - d0, bus.state);
      bad++;
    end
  endtask

  task automatic test_errors();
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd0;
    tick();
    bus.run_req = 1'b0;
    repeat (2) tick();
    bus.load_req = 1'b1;
    bus.load_base = 11'($urandom);
    bus.load_len = 11'($urandom_range(1, 20));
    tick();
    bus.load_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.error !== 1'b1 || bus.state !== 2'b10 || bus.cpu_en !== 1'b1) begin
      $display("FAIL load_in_run: error=%b state=%b cpu_en=%b, required 1/10/1", bus.error, bus.state, bus.cpu_en);
      bad++;
    end
    @(posedge clk);
    #1;
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd3;
    tick();
    bus.run_req = 1'b0;
    repeat (8) tick();
    total++;
    if (bus.state !== 2'b10 || bus.cpu_en !== 1'b1 || bus.w_enable !== 1'b0) begin
      $display("FAIL run_in_run: state=%b cpu_en=%b w_enable=%b, required 10/1/0", bus.state, bus.cpu_en, bus.w_enable);
      bad++;
    end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.state !== 2'b00 || bus.error !== 1'b1) begin
      $display("FAIL error_sticky: state=%b error=%b, required 00/1", bus.state, bus.error);
      bad++;
    end
  endtask

  task automatic test_zero_len();
    int w0;
    int d0;
    w0 = obs_addr.size();
    d0 = mon_done;
    words.delete();
    do_load(11'($urandom), 11'd0, 0, -1, 1'b0);
    total++;
    if (first_state !== 2'b01 || first_ready !== 1'b0) begin
      $display("FAIL zero_len_state: state=%b s_ready=%b, required 01/0", first_state, first_ready);
      bad++;
    end
    total++;
    if (obs_addr.size() != w0 || mon_done - d0 != 1 || bus.state !== 2'b00 || bus.error !== 1'b0) begin
      $display("FAIL zero_len: writes=%0d done_pulses=%0d state=%b error=%b, required 0/1/00/0",
               obs_addr.size() - w0, mon_done - d0, bus.state, bus.error);
      bad++;
    end
  endtask

  task automatic test_simul_req();
    logic [10:0] base;
    int w0;
    int d0;
    int c0;
    base = 11'($urandom);
    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    w0 = obs_addr.size();
    d0 = mon_done;
    c0 = mon_cpu;
    do_load(base, 11'd2, 0, -1, 1'b1);
    total++;
    if (first_state !== 2'b01 || mon_cpu != c0) begin
      $display("FAIL simul_req: state=%b cpu_en cycles=%0d, required 01/0", first_state, mon_cpu - c0);
      bad++;
    end
    total++;
    if (obs_addr.size() - w0 != 2 || mon_done - d0 != 1 ||
        (obs_addr.size() - w0 == 2 && (obs_addr[w0+1] !== 11'((int'(base) + 1) % 2048) || obs_data[w0+1] !== words[1]))) begin
      $display("FAIL simul_load: writes=%0d done_pulses=%0d, required 2 correct writes and 1 done",
               obs_addr.size() - w0, mon_done - d0);
      bad++;
    end
  endtask

  task automatic test_halt_load();
    logic [10:0] base;
    int w0;
    int d0;
    base = 11'($urandom);
    words.delete();
    for (int k = 0; k < 5; k++) words.push_back($urandom);
    w0 = obs_addr.size();
    d0 = mon_done;
    do_load(base, 11'd5, 0, 2, 1'b0);
    total++;
    if (obs_addr.size() - w0 != 3 ||
        (obs_addr.size() - w0 == 3 && (obs_addr[w0+2] !== 11'((int'(base) + 2) % 2048) || obs_data[w0+2] !== words[2]))) begin
      $display("FAIL halt_load_write: writes=%0d, required 3 with last at %h=%h",
               obs_addr.size() - w0, 11'((int'(base) + 2) % 2048), words[2]);
      bad++;
    end
    total++;
    if (mon_done != d0 || bus.error !== 1'b0 || bus.state !== 2'b00 || bus.s_ready !== 1'b0) begin
      $display("FAIL halt_load_end: done_pulses=%0d error=%b state=%b s_ready=%b, required 0/0/00/0",
               mon_done - d0, bus.error, bus.state, bus.s_ready);
      bad++;
    end
  endtask

  task automatic test_checksum();
    words.delete();
    words.push_back(32'd1);
    words.push_back(32'd2);
    words.push_back(32'd3);
    do_load(11'($urandom), 11'd3, 0, -1, 1'b0);
    bus.exp_sum = 32'd7;
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd0;
    tick();
    bus.run_req = 1'b0;
    @(negedge clk);
`ifdef IMEM_BOOT_CHECKSUM_EN
    total++;
    if (bus.state !== 2'b00 || bus.error !== 1'b1 || bus.checksum !== 32'd6) begin
      $display("FAIL checksum_reject: state=%b error=%b checksum=%0d, required 00/1/6", bus.state, bus.error, bus.checksum);
      bad++;
    end
    @(posedge clk);
    #1;
    bus.exp_sum = 32'd6;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== 2'b10 || bus.cpu_en !== 1'b1) begin
      $display("FAIL checksum_accept: state=%b cpu_en=%b, required 10/1", bus.state, bus.cpu_en);
      bad++;
    end
`else
    total++;
    if (bus.state !== 2'b10 || bus.cpu_en !== 1'b1 || bus.checksum !== 32'd0) begin
      $display("FAIL checksum_off: state=%b cpu_en=%b checksum=%h, required 10/1/0", bus.state, bus.cpu_en, bus.checksum);
      bad++;
    end
`endif
    @(posedge clk);
    #1;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_midop();
    // reset while a write is on the bus
    bus.load_req = 1'b1;
    bus.load_base = 11'h123;
    bus.load_len = 11'd4;
    tick();
    bus.load_req = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 32'hA5A5_0F0F;
    tick();
    bus.s_valid = 1'b0;
    total++;
    if (bus.w_enable !== 1'b1 || bus.w_adrs !== 11'h123 || bus.w_instruction !== 32'hA5A5_0F0F) begin
      $display("FAIL pre_reset_write: w_enable=%b w_adrs=%h data=%h, required 1/123/a5a50f0f",
               bus.w_enable, bus.w_adrs, bus.w_instruction);
      bad++;
    end
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({bus.state, bus.s_ready, bus.cpu_en, bus.w_enable, bus.w_adrs, bus.w_instruction, bus.done, bus.error} !== '0) begin
      $display("FAIL reset_midload: state=%b s_ready=%b w_enable=%b w_adrs=%h data=%h, required all 0",
               bus.state, bus.s_ready, bus.w_enable, bus.w_adrs, bus.w_instruction);
      bad++;
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // reset during an unlimited run
    bus.run_req = 1'b1;
    bus.run_cycles = 16'd0;
    tick();
    bus.run_req = 1'b0;
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1;
    total++;
    if (bus.cpu_en !== 1'b0 || bus.state !== 2'b00) begin
      $display("FAIL reset_midrun: cpu_en=%b state=%b, required 0/00", bus.cpu_en, bus.state);
      bad++;
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    bus.load_req   = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.run_req    = 1'b0;
    bus.run_cycles = '0;
    bus.halt_req   = 1'b0;
    bus.exp_sum    = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;

    test_reset();
    test_loads();
    test_bounded_run();
    test_unbounded_halt();
    test_errors();
    test_zero_len();
    test_simul_req();
    test_halt_load();
    test_checksum();
    test_reset_midop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
